// File: rtl/hp_nonce_sweeper.sv
// hp_nonce_sweeper: issues nonce-swept messages to the hash pipe and reports hashes below target
module hp_nonce_sweeper #(
  parameter int WORDBITS   = 32,
  parameter int HASHWORDS  = 8,
  parameter int MSGWORDS   = 16,
  parameter int PIPE_LAT   = 66,
  parameter int NONCE_WORD = 3,
  parameter int HASHBITS   = HASHWORDS*WORDBITS,
  parameter int MSGBITS    = MSGWORDS*WORDBITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MSGBITS-1:0]  header_in,
  input  logic [WORDBITS-1:0] nonce_start,
  input  logic [WORDBITS-1:0] nonce_end,
  input  logic [HASHBITS-1:0] target,
  output logic [MSGBITS-1:0]  req_msg,
  input  logic [HASHBITS-1:0] resp_hash,
  output logic                found_valid,
  input  logic                found_ready,
  output logic [WORDBITS-1:0] found_nonce,
  output logic [HASHBITS-1:0] found_hash,
  output logic                hit_dropped,
  output logic                busy,
  output logic                done
);
  localparam int DW = $clog2(PIPE_LAT+1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_n;
  logic [MSGBITS-1:0] hdr, msg;
  logic [WORDBITS-1:0] cnt, nend;
  logic [HASHBITS-1:0] tgt;
  logic [DW-1:0] drn;
  logic [PIPE_LAT-1:0] v_line;
  logic [WORDBITS-1:0] n_line [PIPE_LAT];
  logic last, hit, accept;
  assign accept = state == IDLE && start;
  assign last = cnt == nend;
  assign hit = v_line[PIPE_LAT-1] && resp_hash < tgt;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: issue until the end nonce, then drain the pipe
  always_comb begin
    state_n = state;
    if (accept) state_n = ISSUE;
    if (state == ISSUE && last) state_n = DRAIN;
    if (state == DRAIN && drn == '0) state_n = IDLE;
  end
  // header with the nonce word replaced by the current counter
  always_comb begin
    msg = hdr;
    msg[MSGBITS-1-NONCE_WORD*WORDBITS -: WORDBITS] = cnt;
  end
  // work latch, nonce/drain counters, message register and status
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hdr <= '0;
      cnt <= '0;
      nend <= '0;
      tgt <= '0;
      drn <= '0;
      req_msg <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (accept) begin
        hdr <= header_in;
        cnt <= nonce_start;
        nend <= nonce_end;
        tgt <= target;
      end else if (state == ISSUE && !last) cnt <= cnt + WORDBITS'(1);
      if (state == ISSUE) drn <= DW'(PIPE_LAT);
      else if (state == DRAIN && drn != '0) drn <= drn - DW'(1);
      req_msg <= state == ISSUE ? msg : '0;
      busy <= state_n != IDLE;
      done <= state == DRAIN && drn == '0;
    end
  // tag line tracking each message through the pipe latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_line <= '0;
      for (int i = 0; i < PIPE_LAT; i++) n_line[i] <= '0;
    end else begin
      v_line[0] <= state == ISSUE;
      n_line[0] <= cnt;
      for (int i = 1; i < PIPE_LAT; i++) begin
        v_line[i] <= v_line[i-1];
        n_line[i] <= n_line[i-1];
      end
    end
  // single-entry found register; hits arriving while it is held are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      found_valid <= 1'b0;
      found_nonce <= '0;
      found_hash <= '0;
      hit_dropped <= 1'b0;
    end else begin
      if (hit && (!found_valid || found_ready)) begin
        found_valid <= 1'b1;
        found_nonce <= n_line[PIPE_LAT-1];
        found_hash <= resp_hash;
      end else if (found_valid && found_ready) found_valid <= 1'b0;
      if (accept) hit_dropped <= 1'b0;
      else if (hit && found_valid && !found_ready) hit_dropped <= 1'b1;
    end
endmodule

// File: tb/tb_hp_nonce_sweeper.sv
// tb_hp_nonce_sweeper: directed checks of issue, compare, handshake and reset behaviour
module tb_hp_nonce_sweeper;
  localparam int PL = 4, MB = 512, HB = 256, NW = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, found_ready = 1'b0;
  logic [MB-1:0] header_in = '0, req_msg, hdr, exp_msg;
  logic [31:0] nonce_start = '0, nonce_end = '0, found_nonce;
  logic [HB-1:0] target = '0, resp_hash, found_hash;
  logic found_valid, hit_dropped, busy, done;
  logic [MB-1:0] pd [PL-1];
  logic [31:0] issued [$], hits [$];
  int hit_cyc [$];
  int n_chk = 0, n_pass = 0, k_done, dcyc, bad;
  logic b1, bd, hd1;
  logic [MB-1:0] first_msg;
  always #5 clk = ~clk;
  hp_nonce_sweeper #(.PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .header_in(header_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .req_msg(req_msg), .resp_hash(resp_hash), .found_valid(found_valid),
    .found_ready(found_ready), .found_nonce(found_nonce), .found_hash(found_hash),
    .hit_dropped(hit_dropped), .busy(busy), .done(done)
  );
  // pipe model: the req_msg register is the first of PL stages; hash = {nonce, 224'b0}
  always @(posedge clk) begin
    pd[0] <= req_msg;
    for (int i = 1; i < PL-1; i++) pd[i] <= pd[i-1];
  end
  assign resp_hash = {pd[PL-2][MB-1-32*NW -: 32], 224'b0};
  task automatic check(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // one sweep; cycle c is the cycle after the c-1'th edge following the start edge
  task automatic sweep(input logic [31:0] s, input logic [31:0] e, input logic [HB-1:0] t,
                       input int rdy_from, input int pulse_c);
    issued.delete();
    hits.delete();
    hit_cyc.delete();
    k_done = -1;
    dcyc = -1;
    first_msg = '0;
    bd = 1'b1;
    header_in = hdr;
    nonce_start = s;
    nonce_end = e;
    target = t;
    found_ready = rdy_from <= 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40 && k_done < 0; c++) begin
      if (c == 1) begin
        b1 = busy;
        hd1 = hit_dropped;
      end
      if (req_msg != '0) begin
        if (issued.size() == 0) first_msg = req_msg;
        issued.push_back(req_msg[MB-1-32*NW -: 32]);
      end
      if (found_valid && found_ready) begin
        hits.push_back(found_nonce);
        hit_cyc.push_back(c);
      end
      if (hit_dropped && dcyc < 0) dcyc = c;
      if (done) begin
        k_done = c;
        bd = busy;
      end
      start = c == pulse_c;
      if (c == pulse_c) begin
        nonce_start = 32'h300;
        target = '1;
      end
      found_ready = c + 1 >= rdy_from;
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    found_ready = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) hdr[MB-1-32*i -: 32] = 32'hC0DE_0000 | i;
    #2;
    check("rst_req_msg", req_msg, '0);
    check("rst_found_valid", found_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hit_dropped", hit_dropped, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(32'h10, 32'h13, {32'h12, 224'b0}, 0, 0);
    exp_msg = hdr;
    exp_msg[MB-1-32*NW -: 32] = 32'h10;
    check("basic_busy_rise", b1, 1);
    check("basic_first_msg", first_msg, exp_msg);
    check("basic_issue_cnt", issued.size(), 4);
    check("basic_issue_last", issued[3], 32'h13);
    check("basic_hit_cnt", hits.size(), 2);
    check("basic_hit0", hits[0], 32'h10);
    check("basic_hit0_cyc", hit_cyc[0], 6);
    check("basic_hit1", hits[1], 32'h11);
    check("basic_hit1_cyc", hit_cyc[1], 7);
    check("basic_done_cyc", k_done, 10);
    check("basic_busy_fall", bd, 0);
    check("basic_no_drop", dcyc, -1);
    check("basic_done_pulse", done, 0);
    sweep(32'h10, 32'h13, {32'h12, 224'b0}, 1000, 0);
    check("bp_no_accept", hits.size(), 0);
    check("bp_drop_cyc", dcyc, 7);
    check("bp_valid", found_valid, 1);
    check("bp_nonce", found_nonce, 32'h10);
    check("bp_hash", found_hash, {32'h10, 224'b0});
    check("bp_dropped", hit_dropped, 1);
    check("bp_done_cyc", k_done, 10);
    found_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    found_ready = 1'b0;
    check("bp_release", found_valid, 0);
    sweep(32'hFFFF_FFFE, 32'h1, '0, 0, 0);
    check("wrap_drop_clear", hd1, 0);
    check("wrap_issue_cnt", issued.size(), 4);
    check("wrap_n0", issued[0], 32'hFFFF_FFFE);
    check("wrap_n1", issued[1], 32'hFFFF_FFFF);
    check("wrap_n2", issued[2], 32'h0);
    check("wrap_n3", issued[3], 32'h1);
    check("wrap_no_hit", hits.size(), 0);
    check("wrap_done_cyc", k_done, 10);
    sweep(32'h5, 32'h5, '0, 0, 0);
    check("single_issue_cnt", issued.size(), 1);
    check("single_nonce", issued[0], 32'h5);
    check("single_done_cyc", k_done, 7);
    sweep(32'h10, 32'h13, {32'h11, 224'b0}, 0, 0);
    check("bound_hit_cnt", hits.size(), 1);
    check("bound_hit0", hits[0], 32'h10);
    sweep(32'h20, 32'h23, {32'h21, 224'b0}, 0, 2);
    check("ign_issue_cnt", issued.size(), 4);
    check("ign_n1", issued[1], 32'h21);
    check("ign_n3", issued[3], 32'h23);
    check("ign_hit_cnt", hits.size(), 1);
    check("ign_done_cyc", k_done, 10);
    sweep(32'h10, 32'h13, {32'h12, 224'b0}, 6, 0);
    check("coll_hit_cnt", hits.size(), 2);
    check("coll_hit0_cyc", hit_cyc[0], 6);
    check("coll_hit1", hits[1], 32'h11);
    check("coll_hit1_cyc", hit_cyc[1], 7);
    check("coll_no_drop", dcyc, -1);
    header_in = hdr;
    nonce_start = 32'h10;
    nonce_end = 32'h1F;
    target = {32'h20, 224'b0};
    found_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_pre_valid", found_valid, 1);
    check("mid_pre_drop", hit_dropped, 1);
    check("mid_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_req_msg", req_msg, '0);
    check("mid_found_valid", found_valid, 0);
    check("mid_found_nonce", found_nonce, 0);
    check("mid_found_hash", found_hash, '0);
    check("mid_hit_dropped", hit_dropped, 0);
    check("mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (found_valid || done || busy) bad++;
    end
    check("mid_no_late_activity", bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
